// File: rtl/cdb_scheduler.sv
// cdb_scheduler: round-robin two-lane common data bus scheduler with registered grants.
// Optional statistics counters are enabled by defining CDB_SCHEDULER_STATS_EN.
module cdb_scheduler #(
  parameter int REQUESTERS = 4,
  parameter int BUSES = 2,
  parameter logic [7:0] BASE_ADDRESS = 8'h00
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic [REQUESTERS-1:0] request,
  output logic [REQUESTERS-1:0] grant,
  output logic [BUSES-1:0][7:0] select,
`ifdef CDB_SCHEDULER_STATS_EN
  output logic [BUSES-1:0][31:0] busy_count,
  output logic [31:0] stall_count,
`endif
  output logic [REQUESTERS-1:0] lane_of
);
  localparam int PW = REQUESTERS > 1 ? $clog2(REQUESTERS) : 1;
  if (int'(BASE_ADDRESS) + REQUESTERS - 1 >= 255) begin : g_bad_base
    $error("cdb_scheduler: BASE_ADDRESS + REQUESTERS - 1 collides with idle address 8'hFF");
  end
  logic [PW-1:0] ptr, n_ptr;
  logic [REQUESTERS-1:0] n_grant, n_lane;
  logic [BUSES-1:0][7:0] n_sel;
  int idx, n;
  always_comb begin
    n_grant = '0;
    n_lane = '0;
    n_sel = {BUSES{8'hFF}};
    n_ptr = ptr;
    idx = 0;
    n = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      idx = (int'(ptr) + k) % REQUESTERS;
      if (request[idx] && n < BUSES) begin
        n_grant[idx] = 1'b1;
        n_lane[idx] = n[0];
        n_sel[n[0]] = BASE_ADDRESS + 8'(idx);
        n_ptr = PW'((idx + 1) % REQUESTERS);
        n = n + 1;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      grant <= '0;
      select <= {BUSES{8'hFF}};
      lane_of <= '0;
    end else if (clear) begin
      grant <= '0;
      select <= {BUSES{8'hFF}};
      lane_of <= '0;
    end else begin
      ptr <= n_ptr;
      grant <= n_grant;
      select <= n_sel;
      lane_of <= n_lane;
    end
  end
`ifdef CDB_SCHEDULER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_count <= '0;
      stall_count <= '0;
    end else begin
      for (int b = 0; b < BUSES; b++)
        busy_count[b] <= (select[b] != 8'hFF && busy_count[b] != '1) ? busy_count[b] + 32'd1 : busy_count[b];
      stall_count <= ($countones(request) > BUSES && stall_count != '1) ? stall_count + 32'd1 : stall_count;
    end
  end
`endif
endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler: directed vector table plus randomized run against a queue-based scan model.
module tb_cdb_scheduler;
  localparam int R = 4;
  logic clock = 0, reset = 0, clear = 0;
  logic [R-1:0] request = '0;
  logic [R-1:0] grant, lane_of;
  logic [1:0][7:0] select;
`ifdef CDB_SCHEDULER_STATS_EN
  logic [1:0][31:0] busy_count;
  logic [31:0] stall_count;
`endif
  int vectors = 0, miscompares = 0;
  int m_ptr = 0;
  logic [R-1:0] m_grant = '0, m_lane = '0;
  logic [7:0] m_sel0 = 8'hFF, m_sel1 = 8'hFF;

  cdb_scheduler #(.REQUESTERS(R), .BUSES(2), .BASE_ADDRESS(8'h00)) dut (
    .clock(clock), .reset(reset), .clear(clear), .request(request),
    .grant(grant), .select(select),
`ifdef CDB_SCHEDULER_STATS_EN
    .busy_count(busy_count), .stall_count(stall_count),
`endif
    .lane_of(lane_of)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst, clr;
    logic [3:0] req, grant, lane;
    logic [7:0] sel0, sel1;
  } vec_t;

  // Model: list requesters in scan order from the pointer, the first two win.
  task automatic model(input logic r, input logic c, input logic [3:0] q);
    int order[$];
    m_grant = '0; m_lane = '0; m_sel0 = 8'hFF; m_sel1 = 8'hFF;
    if (r) begin
      m_ptr = 0;
      return;
    end
    if (c) return;
    for (int k = 0; k < R; k++)
      if (q[(m_ptr + k) % R]) order.push_back((m_ptr + k) % R);
    if (order.size() >= 1) begin
      m_grant[order[0]] = 1'b1;
      m_sel0 = 8'(order[0]);
      m_ptr = (order[0] + 1) % R;
    end
    if (order.size() >= 2) begin
      m_grant[order[1]] = 1'b1;
      m_lane[order[1]] = 1'b1;
      m_sel1 = 8'(order[1]);
      m_ptr = (order[1] + 1) % R;
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [3:0] q);
    reset = r; clear = c; request = q;
    @(posedge clock);
    model(r, c, q);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [7:0] s0, input logic [7:0] s1, input logic [3:0] l);
    vectors++;
    if (grant !== g || select[0] !== s0 || select[1] !== s1 || (lane_of & grant) !== (l & g)) begin
      miscompares++;
      $display("FAIL %s: got grant=%b sel=%h/%h lane_of=%b, want grant=%b sel=%h/%h lane_of=%b",
               name, grant, select[0], select[1], lane_of, g, s0, s1, l);
    end
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1,0,4'hF,4'b0000,4'b0000,8'hFF,8'hFF};
    tbl[1]  = '{1,0,4'hF,4'b0000,4'b0000,8'hFF,8'hFF};
    tbl[2]  = '{0,0,4'hF,4'b0011,4'b0010,8'h00,8'h01};
    tbl[3]  = '{0,0,4'hF,4'b1100,4'b1000,8'h02,8'h03};
    tbl[4]  = '{0,0,4'hF,4'b0011,4'b0010,8'h00,8'h01};
    tbl[5]  = '{0,0,4'h4,4'b0100,4'b0000,8'h02,8'hFF};
    tbl[6]  = '{0,0,4'h4,4'b0100,4'b0000,8'h02,8'hFF};
    tbl[7]  = '{0,0,4'h4,4'b0100,4'b0000,8'h02,8'hFF};
    tbl[8]  = '{0,0,4'h9,4'b1001,4'b0001,8'h03,8'h00};
    tbl[9]  = '{0,1,4'h3,4'b0000,4'b0000,8'hFF,8'hFF};
    tbl[10] = '{0,0,4'h3,4'b0011,4'b0001,8'h01,8'h00};
    tbl[11] = '{0,0,4'h0,4'b0000,4'b0000,8'hFF,8'hFF};
    tbl[12] = '{1,1,4'hF,4'b0000,4'b0000,8'hFF,8'hFF};
    tbl[13] = '{0,0,4'hF,4'b0011,4'b0010,8'h00,8'h01};
    @(negedge clock);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].req);
      check($sformatf("vec%0d", i), tbl[i].grant, tbl[i].sel0, tbl[i].sel1, tbl[i].lane);
    end
    // Reset in mid-stream: the following cycle is idle whatever is requested.
    step(1, 0, 4'hF);
    check("mid_reset", 4'b0000, 8'hFF, 8'hFF, 4'b0000);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] q;
      logic c, r;
      q = 4'($urandom);
      c = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 63) == 0);
      step(r, c, q);
      check($sformatf("rand%0d", i), m_grant, m_sel0, m_sel1, m_lane);
    end
`ifdef CDB_SCHEDULER_STATS_EN
    step(1, 0, 4'h0);
    for (int i = 0; i < 10; i++) step(0, 0, 4'b0111);
    step(0, 0, 4'h0);
    vectors++;
    if (busy_count[0] !== 32'd10 || busy_count[1] !== 32'd10 || stall_count !== 32'd10) begin
      miscompares++;
      $display("FAIL stats: got busy=%0d/%0d stall=%0d, want 10/10 stall=10",
               busy_count[0], busy_count[1], stall_count);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cdb_scheduler.md
# cdb_scheduler

Central scheduler for the two common data bus lanes shared by all execution combos (ALU, branch, load/store, mul/div). Each cycle it picks up to two requesting combos in round-robin order, assigns each to one bus lane, and drives the lane `select` addresses that the per-combo arbiters decode into `bus_granted`/`bus_selected`. Grants are registered: a combo requesting in cycle t owns its lane in cycle t+1.

## Interface
Parameters:
- `REQUESTERS`, 4: number of execution combos sharing the buses (2..8).
- `BUSES`, 2: number of common data bus lanes (fixed at 2 for this revision).
- `BASE_ADDRESS`, 8'h00: arbiter address of requester 0; requester i has address `BASE_ADDRESS + i`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  pipeline flush; cancels next-cycle grants.
- `request`  in  REQUESTERS  bit i high: combo i has a result for the next cycle.
- `grant`  out  REQUESTERS  bit i high: combo i owns a lane this cycle.
- `select`  out  BUSES x 8  lane b owner address; 8'hFF = idle.
- `lane_of`  out  REQUESTERS x 1  lane index owned by combo i (valid only with `grant[i]`).

## Operation
- Registered state: round-robin pointer `ptr` (log2 REQUESTERS bits), `grant`, `select`, `lane_of`.
- Each cycle, scan `request` starting at index `ptr`, wrapping modulo REQUESTERS. First requester found gets lane 0, second gets lane 1; all others are denied. Denied combos keep `request` high. The scheduler never drops a pending request.
- Pointer update: `ptr <= (index of last granted requester + 1) mod REQUESTERS`. If nothing is granted, `ptr` holds.
- `request` is level-sensitive. Each cycle in which `grant[i]` is high consumes one result. If `request[i]` is high in the same cycle, combo i is asking for another slot in the following cycle, so back-to-back grants to the same combo are legal.
- `clear` high in cycle t: registered outputs for t+1 are idle (`grant`=0, `select`=8'hFF, `lane_of`=0). `ptr` holds. Grants already visible in cycle t complete normally.
- `reset` high: `ptr`=0, `grant`=0, all `select`=8'hFF, `lane_of`=0; statistics counters (if present) = 0. Reset dominates `clear`.
- An address never appears on both lanes in the same cycle. Lane 1 is never busy while lane 0 is idle.
- `BASE_ADDRESS + REQUESTERS - 1` must be below 8'hFF. This is checked by an elaboration-time assertion.

## Timing
- Latency: `request` sampled at edge t, result (`grant`/`select`/`lane_of`) valid for all of cycle t+1.
- Throughput: 2 grants per cycle whenever 2 or more requests are pending.
- Fairness: a continuously requesting combo is granted within ceil(REQUESTERS/2) cycles.
- Outputs are pure flops, with no combinational path from `request` to any output.
- A reset in mid-stream takes effect at the next edge. The cycle after reset is idle regardless of `request`.

## Configuration
- `CDB_SCHEDULER_STATS_EN` defined: adds outputs `busy_count` (out, BUSES x 32, per lane, counts cycles with non-idle `select`) and `stall_count` (out, 32, counts cycles where the number of pending requests exceeds BUSES). Both counters saturate at 32'hFFFF_FFFF, clear on reset, and are unaffected by `clear`.
- Undefined: these ports and counters do not exist. Scheduling behaviour is identical in both builds.

## Test plan
- Reset: hold `reset` 2 cycles with `request`=4'b1111. Required: `grant`=0 and `select`={8'hFF,8'hFF} during and 1 cycle after reset. First grants {0,1} appear on the 2nd cycle after release.
- Single requester: `request`=4'b0100 for 3 cycles. Required: `grant`=4'b0100, `select[0]`=8'h02, `select[1]`=8'hFF, `lane_of[2]`=0 in each following cycle; back-to-back grants.
- Round-robin: `request`=4'b1111 held with `ptr`=0. Required grant sequence is {0,1}, {2,3}, {0,1}, with lane 0 = lower index in scan order.
- Wrap: `ptr`=3, `request`=4'b1001. Required: lane 0 = combo 3 (8'h03), lane 1 = combo 0 (8'h00), new `ptr`=1.
- Flush: `request`=4'b0011 with `clear` pulsed 1 cycle. Required: the next cycle is idle, `ptr` is unchanged, and grants {0,1} resume in the cycle after.
- Stats (macro on): `request`=4'b0111 for 10 cycles. Required: `busy_count` = {10,10} and `stall_count`=10 one cycle after the last grant.
